// File: rtl/mnist_dlayer_pkg.sv
// rtl/mnist_dlayer_pkg.sv - shared defaults and FSM state type for the dense-layer gather block
package mnist_dlayer_pkg;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_NUM_OUT = 20;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_WAIT    = 1'b1
  } state_t;

endpackage

// File: rtl/mnist_dlayer_relu.sv
// rtl/mnist_dlayer_relu.sv - combinational ReLU clamp: negative two's-complement values become zero
module mnist_dlayer_relu
  import mnist_dlayer_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  assign dout = din[DATA_W-1] ? '0 : din;

endmodule

// File: rtl/mnist_dlayer_gather.sv
// rtl/mnist_dlayer_gather.sv - serial-to-parallel result packer; ReLU on stored beats when MNIST_DLAYER_RELU_EN is defined
module mnist_dlayer_gather
  import mnist_dlayer_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int NUM_OUT = DEF_NUM_OUT,
  localparam int CNT_W  = $clog2(NUM_OUT + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         in_data,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NUM_OUT*DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]          out_count,
  output logic                      out_short
);

  state_t                      state;
  logic [CNT_W-1:0]            cnt;
  logic [CNT_W-1:0]            pend_count;
  logic                        pend_short;
  logic [NUM_OUT*DATA_W-1:0]   acc;
  logic [NUM_OUT*DATA_W-1:0]   frame;
  logic [DATA_W-1:0]           beat;
  logic                        accept;
  logic                        done;
  logic                        last_slot;
  logic                        out_free;

`ifdef MNIST_DLAYER_RELU_EN
  mnist_dlayer_relu #(.DATA_W(DATA_W)) u_relu (
    .din  (in_data),
    .dout (beat)
  );
`else
  assign beat = in_data;
`endif

  assign in_ready  = (state == ST_COLLECT) && !clr;
  assign accept    = in_valid && in_ready;
  assign last_slot = (cnt == CNT_W'(NUM_OUT - 1));
  assign done      = accept && (last_slot || in_last);
  assign out_free  = !out_valid || out_ready;

  // Accumulator is kept zero above cnt, so a short frame's unused slots load as zero.
  always_comb begin
    frame = acc;
    for (int k = 0; k < NUM_OUT; k++) begin
      if (cnt == CNT_W'(k)) frame[k*DATA_W +: DATA_W] = beat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_COLLECT;
      cnt        <= '0;
      acc        <= '0;
      pend_count <= '0;
      pend_short <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_count  <= '0;
      out_short  <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (clr) begin
        state <= ST_COLLECT;
        cnt   <= '0;
        acc   <= '0;
      end else begin
        case (state)
          ST_COLLECT: begin
            if (accept) begin
              if (!done) begin
                acc <= frame;
                cnt <= cnt + CNT_W'(1);
              end else if (out_free) begin
                out_data  <= frame;
                out_valid <= 1'b1;
                out_count <= cnt + CNT_W'(1);
                out_short <= !last_slot;
                cnt       <= '0;
                acc       <= '0;
              end else begin
                acc        <= frame;
                pend_count <= cnt + CNT_W'(1);
                pend_short <= !last_slot;
                state      <= ST_WAIT;
              end
            end
          end
          ST_WAIT: begin
            // out_valid is always set here, so out_ready alone means the held frame leaves.
            if (out_ready) begin
              out_data  <= acc;
              out_valid <= 1'b1;
              out_count <= pend_count;
              out_short <= pend_short;
              cnt       <= '0;
              acc       <= '0;
              state     <= ST_COLLECT;
            end
          end
          default: state <= ST_COLLECT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mnist_dlayer_gather.sv
// tb/tb_mnist_dlayer_gather.sv - directed self-checking bench for mnist_dlayer_gather
module tb_mnist_dlayer_gather;

  localparam int DATA_W  = 32;
  localparam int NUM_OUT = 20;
  localparam int CNT_W   = $clog2(NUM_OUT + 1);

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      clr;
  logic                      in_valid;
  logic                      in_ready;
  logic [DATA_W-1:0]         in_data;
  logic                      in_last;
  logic                      out_valid;
  logic                      out_ready;
  logic [NUM_OUT*DATA_W-1:0] out_data;
  logic [NUM_OUT*DATA_W-1:0] saved;
  logic [CNT_W-1:0]          out_count;
  logic                      out_short;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mnist_dlayer_gather #(.DATA_W(DATA_W), .NUM_OUT(NUM_OUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .out_short (out_short)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DATA_W-1:0] d, input logic last);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    #0;
    while (!in_ready && t < 100) begin
      step();
      t++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL push_timeout in_ready=%0b required 1", in_ready);
    end
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    checks += 5;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %0b exp 0", out_valid); end
    if (out_data !== '0) begin errors++; $display("FAIL rst_out_data got %0h exp 0", out_data); end
    if (out_count !== '0) begin errors++; $display("FAIL rst_out_count got %0d exp 0", out_count); end
    if (out_short !== 1'b0) begin errors++; $display("FAIL rst_out_short got %0b exp 0", out_short); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %0b exp 1", in_ready); end
  endtask

  task automatic test_full_frame();
    out_ready = 1'b1;
    for (int k = 0; k < NUM_OUT; k++) begin
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL full_in_ready beat %0d got %0b exp 1", k, in_ready); end
      if (k == NUM_OUT - 1) begin
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL full_early_valid got %0b exp 0", out_valid); end
      end
      push(DATA_W'(k + 1), 1'b0);
    end
    checks += 3;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL full_out_valid got %0b exp 1", out_valid); end
    if (out_count !== CNT_W'(20)) begin errors++; $display("FAIL full_out_count got %0d exp 20", out_count); end
    if (out_short !== 1'b0) begin errors++; $display("FAIL full_out_short got %0b exp 0", out_short); end
    for (int k = 0; k < NUM_OUT; k++) begin
      checks++;
      if (out_data[k*DATA_W +: DATA_W] !== DATA_W'(k + 1))
        begin errors++; $display("FAIL full_slot%0d got %0h exp %0h", k, out_data[k*DATA_W +: DATA_W], k + 1); end
    end
    saved = out_data;
    step();
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL full_valid_drop got %0b exp 0", out_valid); end
    if (out_data !== saved) begin errors++; $display("FAIL full_data_hold got %0h exp %0h", out_data, saved); end
  endtask

  task automatic test_wait();
    out_ready = 1'b0;
    for (int k = 0; k < NUM_OUT; k++) push(DATA_W'(100 + k), 1'b0);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL wait_a_valid got %0b exp 1", out_valid); end
    for (int k = 0; k < NUM_OUT; k++) push(DATA_W'(200 + k), 1'b0);
    repeat (2) begin
      checks += 3;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL wait_in_ready got %0b exp 0", in_ready); end
      if (out_valid !== 1'b1) begin errors++; $display("FAIL wait_hold_valid got %0b exp 1", out_valid); end
      if (out_data[0 +: DATA_W] !== 32'd100 || out_data[19*DATA_W +: DATA_W] !== 32'd119)
        begin errors++; $display("FAIL wait_a_stable got %0h exp A frame", out_data); end
      step();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL wait_bubble got %0b exp 0", in_ready); end
    step();
    checks += 3;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL wait_b_valid got %0b exp 1", out_valid); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL wait_exit_ready got %0b exp 1", in_ready); end
    if (out_count !== CNT_W'(20)) begin errors++; $display("FAIL wait_b_count got %0d exp 20", out_count); end
    for (int k = 0; k < NUM_OUT; k++) begin
      checks++;
      if (out_data[k*DATA_W +: DATA_W] !== DATA_W'(200 + k))
        begin errors++; $display("FAIL wait_b_slot%0d got %0h exp %0h", k, out_data[k*DATA_W +: DATA_W], 200 + k); end
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL wait_b_drop got %0b exp 0", out_valid); end
  endtask

  task automatic test_short();
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) push(DATA_W'(32'hA + k), k == 4);
    checks += 3;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL short_valid got %0b exp 1", out_valid); end
    if (out_count !== CNT_W'(5)) begin errors++; $display("FAIL short_count got %0d exp 5", out_count); end
    if (out_short !== 1'b1) begin errors++; $display("FAIL short_flag got %0b exp 1", out_short); end
    for (int k = 0; k < NUM_OUT; k++) begin
      checks++;
      if (out_data[k*DATA_W +: DATA_W] !== ((k < 5) ? DATA_W'(32'hA + k) : '0))
        begin errors++; $display("FAIL short_slot%0d got %0h exp %0h", k, out_data[k*DATA_W +: DATA_W], (k < 5) ? 32'hA + k : 0); end
    end
    step();
  endtask

  task automatic test_clr();
    out_ready = 1'b1;
    saved = out_data;
    for (int k = 0; k < 7; k++) push(DATA_W'(300 + k), 1'b0);
    clr = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD; in_last = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL clr_in_ready got %0b exp 0", in_ready); end
    step();
    clr = 1'b0; in_valid = 1'b0;
    checks += 2;
    if (out_data !== saved) begin errors++; $display("FAIL clr_data_hold got %0h exp %0h", out_data, saved); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL clr_valid got %0b exp 0", out_valid); end
    for (int k = 0; k < NUM_OUT; k++) push(DATA_W'(400 + k), 1'b0);
    checks += 2;
    if (out_count !== CNT_W'(20)) begin errors++; $display("FAIL clr_count got %0d exp 20", out_count); end
    if (out_short !== 1'b0) begin errors++; $display("FAIL clr_short got %0b exp 0", out_short); end
    for (int k = 0; k < NUM_OUT; k++) begin
      checks++;
      if (out_data[k*DATA_W +: DATA_W] !== DATA_W'(400 + k))
        begin errors++; $display("FAIL clr_slot%0d got %0h exp %0h", k, out_data[k*DATA_W +: DATA_W], 400 + k); end
    end
    step();
  endtask

  task automatic test_relu();
    logic [DATA_W-1:0] exp0;
`ifdef MNIST_DLAYER_RELU_EN
    exp0 = 32'h0000_0000;
`else
    exp0 = 32'hFFFF_FFFF;
`endif
    out_ready = 1'b1;
    push(32'hFFFF_FFFF, 1'b0);
    push(32'h7FFF_FFFF, 1'b1);
    checks += 4;
    if (out_count !== CNT_W'(2)) begin errors++; $display("FAIL relu_count got %0d exp 2", out_count); end
    if (out_data[0 +: DATA_W] !== exp0) begin errors++; $display("FAIL relu_slot0 got %0h exp %0h", out_data[0 +: DATA_W], exp0); end
    if (out_data[DATA_W +: DATA_W] !== 32'h7FFF_FFFF) begin errors++; $display("FAIL relu_slot1 got %0h exp 7fffffff", out_data[DATA_W +: DATA_W]); end
    if (out_data[2*DATA_W +: DATA_W] !== '0) begin errors++; $display("FAIL relu_slot2 got %0h exp 0", out_data[2*DATA_W +: DATA_W]); end
    step();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < NUM_OUT; k++) begin
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready f%0d b%0d got %0b exp 1", f, k, in_ready); end
        push(DATA_W'(700 + 100 * f + k), 1'b0);
      end
      checks += 3;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid f%0d got %0b exp 1", f, out_valid); end
      if (out_data[0 +: DATA_W] !== DATA_W'(700 + 100 * f)) begin errors++; $display("FAIL b2b_first f%0d got %0h exp %0h", f, out_data[0 +: DATA_W], 700 + 100 * f); end
      if (out_data[19*DATA_W +: DATA_W] !== DATA_W'(719 + 100 * f)) begin errors++; $display("FAIL b2b_last f%0d got %0h exp %0h", f, out_data[19*DATA_W +: DATA_W], 719 + 100 * f); end
    end
    step();
  endtask

  task automatic test_reset_in_wait();
    out_ready = 1'b0;
    for (int k = 0; k < NUM_OUT; k++) push(DATA_W'(500 + k), 1'b0);
    for (int k = 0; k < 10; k++) push(DATA_W'(550 + k), 1'b0);
    push(DATA_W'(560), 1'b1);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL rw_wait_ready got %0b exp 0", in_ready); end
    rst_n = 1'b0;
    #1;
    checks += 5;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rw_out_valid got %0b exp 0", out_valid); end
    if (out_data !== '0) begin errors++; $display("FAIL rw_out_data got %0h exp 0", out_data); end
    if (out_count !== '0) begin errors++; $display("FAIL rw_out_count got %0d exp 0", out_count); end
    if (out_short !== 1'b0) begin errors++; $display("FAIL rw_out_short got %0b exp 0", out_short); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rw_in_ready got %0b exp 1", in_ready); end
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    for (int k = 0; k < NUM_OUT; k++) push(DATA_W'(600 + k), 1'b0);
    checks += 3;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL rw_new_valid got %0b exp 1", out_valid); end
    if (out_count !== CNT_W'(20)) begin errors++; $display("FAIL rw_new_count got %0d exp 20", out_count); end
    if (out_short !== 1'b0) begin errors++; $display("FAIL rw_new_short got %0b exp 0", out_short); end
    for (int k = 0; k < NUM_OUT; k++) begin
      checks++;
      if (out_data[k*DATA_W +: DATA_W] !== DATA_W'(600 + k))
        begin errors++; $display("FAIL rw_slot%0d got %0h exp %0h", k, out_data[k*DATA_W +: DATA_W], 600 + k); end
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_wait();
    test_short();
    test_clr();
    test_relu();
    test_back_to_back();
    test_reset_in_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mnist_dlayer_gather.md
# mnist_dlayer_gather

Parametrised serial-to-parallel result collector for the MNIST dense layers. It accepts one node result per cycle from a time-multiplexed dense-layer node and packs `NUM_OUT` results into one wide output vector. A ready/valid handshake runs on both sides, and the block supports short frames and per-element ReLU. Packed vectors feed the next dense layer's `im` bus or the classifier.

## Interface
- `DATA_W`, 32: width of one node result, two's complement.
- `NUM_OUT`, 20: results per frame (≥1).
- `CNT_W`, `$clog2(NUM_OUT+1)`: derived, not overridden.

Ports (reset rst_n is asynchronous, active-low; clock is clk):
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `clr`  in  1  synchronous clear; drops the partial frame.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  input beat accepted when `in_valid & in_ready`.
- `in_data`  in  DATA_W  node result.
- `in_last`  in  1  final beat of frame; may arrive early.
- `out_valid`  out  1  packed frame available.
- `out_ready`  in  1  downstream accepts frame.
- `out_data`  out  NUM_OUT*DATA_W  packed frame; beat k sits at `[k*DATA_W +: DATA_W]`, first beat at the LSB.
- `out_count`  out  CNT_W  number of valid beats in the frame (1..NUM_OUT).
- `out_short`  out  1  frame ended by `in_last` before NUM_OUT beats.

## Operation
- Internal state: an accumulator of NUM_OUT slots plus a separate output register; `cnt` counts accepted beats (0..NUM_OUT-1).
- FSM states:
  - COLLECT: `in_ready = ~clr`.
  - WAIT: a complete frame is held in the accumulator and the output register is occupied; `in_ready = 0`.
- An accepted beat writes slot `cnt` (after the optional ReLU) and increments `cnt`.
- A beat completes the frame if `cnt == NUM_OUT-1` or `in_last == 1`.
  - If the output register is free (`~out_valid | out_ready`), on that edge:
    - the frame, including the completing beat, loads into `out_data`;
    - `out_valid` becomes 1;
    - `cnt`, the accumulator and `out_count`/`out_short` are updated accordingly;
    - the state stays COLLECT.
  - Otherwise the state goes to WAIT.
- WAIT → COLLECT on the first edge with `out_ready` high. The pending frame loads into the output register at that edge, and `cnt` returns to 0.
- Short frame: slots `cnt+1..NUM_OUT-1` load as zero; `out_short = 1`; `out_count` = beats received.
- `in_last` on beat NUM_OUT-1 is a normal full frame.
- `out_valid` drops after a handshake unless a new frame loads on the same edge.
- `out_data`, `out_count` and `out_short` keep their last frame value after the handshake; they change only on the next load.
- `clr`:
  - `cnt` → 0, accumulator → 0, state → COLLECT; any WAIT frame is discarded.
  - A beat presented in the same cycle is not accepted (`in_ready = 0`).
  - The output register and `out_valid` are unaffected.
- `NUM_OUT == 1`: every accepted beat completes a frame.

## Timing
- Reset values: `out_valid = 0`, `out_data = 0`, `out_count = 0`, `out_short = 0`, `in_ready = 1`; `cnt = 0`; state COLLECT; accumulator zero.
- Latency: `out_valid` rises in the cycle after the edge that accepts the completing beat.
- Throughput: one beat per cycle. With `out_ready` held high, frames run back-to-back with no input bubble. Leaving WAIT costs one input bubble cycle.
- `out_data` is stable while `out_valid & ~out_ready`.
- Reset mid-frame discards all partial and pending data.

## Configuration
- `MNIST_DLAYER_RELU_EN` defined: each accepted beat with its MSB set is stored as zero; non-negative values pass unchanged.
- Undefined: beats are stored unchanged, and no ReLU logic is instantiated.

## Structure
- Package `mnist_dlayer_pkg` holds:
  - default `DATA_W` and `NUM_OUT` constants;
  - the FSM state typedef (COLLECT, WAIT).
- One sub-module, `mnist_dlayer_relu`: a combinational DATA_W clamp, instantiated only under `MNIST_DLAYER_RELU_EN`.

## Test plan
1. NUM_OUT=20, DATA_W=32, beats 1..20 back-to-back, `out_ready=1` → `out_valid` one cycle after beat 20; slot k = k+1; `out_count=20`; `out_short=0`; `in_ready` never drops.
2. `out_ready=0`: frame A completes, then frame B streams; beat 20 of B stalls with `in_ready=0` (WAIT). Raise `out_ready` → A handshakes; B appears in `out_data` the next cycle; one input bubble.
3. Five beats 0xA..0xE, `in_last` on the fifth → `out_count=5`, `out_short=1`, slots 5..19 = 0.
4. Seven beats, then `clr` together with `in_valid` → that beat is not accepted; `out_data` is unchanged; the next 20 beats fill from slot 0.
5. Macro on: beats 32'hFFFF_FFFF and 32'h7FFF_FFFF → slots 0 and 32'h7FFF_FFFF. Macro off → both stored unchanged.
6. `rst_n` low after 10 beats with a frame pending in WAIT → all outputs at reset values. After release, 20 new beats produce one correct frame.
